forwarding_hazard_unit: RTL and testbench

//  Parametrised forwarding and hazard unit for the 5-stage pipeline (D/E/M/W). Owns the E, M, W

---
 rtl/forwarding_hazard_unit_pkg.sv | 33 +++
 rtl/forwarding_hazard_unit_if.sv | 42 ++++
 rtl/forwarding_hazard_unit_fwd_src_mux.sv | 54 +++++
 rtl/forwarding_hazard_unit.sv | 129 ++++++++++++
 tb/tb_forwarding_hazard_unit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared types for the forwarding/hazard unit.
// Stage tag layout, forward-select encodings and default widths.
package forwarding_hazard_unit_pkg;

  localparam int DATA_W_P  = 16;
  localparam int AW_P      = 4;
  localparam int NUM_SRC_P = 2;
  localparam int SEL_W     = 2;

  typedef logic [SEL_W-1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_NONE = 2'd0;
  localparam fwd_sel_t FWD_M    = 2'd1;
  localparam fwd_sel_t FWD_W    = 2'd2;

  typedef struct packed {
    logic                            valid;
    logic                            we;
    logic [AW_P-1:0]                 dst;
    logic                            is_load;
    logic                            is_store;
    logic [NUM_SRC_P-1:0][AW_P-1:0]  src_addr;
    logic [NUM_SRC_P-1:0]            src_used;
  } stage_tag_t;

  function automatic logic addr_live(
    input logic [AW_P-1:0] a,
    input logic            zero_reg
  );
    return !zero_reg || (a != '0);
  endfunction

endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// Decode/bypass bundle between the pipeline and the forwarding unit.
// master drives decode and bypass data, slave returns operands and stall.
interface forwarding_hazard_unit_if #(
  parameter int DATA_W  = 16,
  parameter int AW      = 4,
  parameter int NUM_SRC = 2
);
  logic                      hold;
  logic                      flush;
  logic                      d_valid;
  logic [NUM_SRC-1:0]        d_src_used;
  logic [NUM_SRC*AW-1:0]     d_src_addr;
  logic [NUM_SRC*DATA_W-1:0] d_src_data;
  logic [AW-1:0]             d_dst_addr;
  logic                      d_dst_we;
  logic                      d_is_load;
  logic                      d_is_store;
  logic [DATA_W-1:0]         m_alu_result;
  logic [DATA_W-1:0]         w_reg_write_data;
  logic                      stall;
  logic [NUM_SRC*DATA_W-1:0] e_operand;
  logic [NUM_SRC*2-1:0]      e_fwd_sel;
  logic [DATA_W-1:0]         m_store_data;
  logic                      w_reg_we;
  logic [AW-1:0]             w_reg_addr;

  modport master (
    output hold, flush, d_valid, d_src_used, d_src_addr,
    output d_src_data, d_dst_addr, d_dst_we, d_is_load,
    output d_is_store, m_alu_result, w_reg_write_data,
    input  stall, e_operand, e_fwd_sel, m_store_data,
    input  w_reg_we, w_reg_addr
  );

  modport slave (
    input  hold, flush, d_valid, d_src_used, d_src_addr,
    input  d_src_data, d_dst_addr, d_dst_we, d_is_load,
    input  d_is_store, m_alu_result, w_reg_write_data,
    output stall, e_operand, e_fwd_sel, m_store_data,
    output w_reg_we, w_reg_addr
  );
endinterface

// File: rtl/forwarding_hazard_unit_fwd_src_mux.sv
// Per-source bypass match and operand select for the E stage.
// M wins over W because it holds the newer value.
module fwd_src_mux
  import forwarding_hazard_unit_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int AW       = 4,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              m_valid,
  input  logic              m_we,
  input  logic [AW-1:0]     m_dst,
  input  logic              w_valid,
  input  logic              w_we,
  input  logic [AW-1:0]     w_dst,
  input  logic [AW-1:0]     src_addr,
  input  logic              src_used,
  input  logic [DATA_W-1:0] m_data,
  input  logic [DATA_W-1:0] w_data,
  input  logic [DATA_W-1:0] latched,
  output logic [DATA_W-1:0] operand,
  output fwd_sel_t          sel,
  output logic              match_m
);

  logic live;
  logic match_w;

  assign live    = !ZERO_REG || (src_addr != '0);
  assign match_m = m_valid & m_we & (m_dst == src_addr)
                 & src_used & live;
  assign match_w = w_valid & w_we & (w_dst == src_addr)
                 & src_used & live;

  always_comb begin
    operand = latched;
    sel     = FWD_NONE;
    priority case (1'b1)
      match_m: begin
        operand = m_data;
        sel     = FWD_M;
      end
      match_w: begin
        operand = w_data;
        sel     = FWD_W;
      end
      default: begin
        operand = latched;
        sel     = FWD_NONE;
      end
    endcase
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// E/M/W tag pipeline, E operand registers, load-use stall
// and MEM-to-MEM store-data forwarding.
module forwarding_hazard_unit
  import forwarding_hazard_unit_pkg::*;
#(
  parameter int DATA_W   = DATA_W_P,
  parameter int AW       = AW_P,
  parameter int NUM_SRC  = NUM_SRC_P,
  parameter bit ZERO_REG = 1'b1
) (
  input logic clk,
  input logic rst,
  forwarding_hazard_unit_if.slave bus
);

  stage_tag_t d_tag;
  stage_tag_t e_tag;
  stage_tag_t m_tag;
  stage_tag_t w_tag;

  logic [NUM_SRC-1:0][DATA_W-1:0] d_opnd;
  logic [NUM_SRC-1:0][DATA_W-1:0] e_opnd_q;
  logic [NUM_SRC-1:0][DATA_W-1:0] e_opnd;
  logic [NUM_SRC-1:0][1:0]        e_sel;
  logic [DATA_W-1:0]              m_store_q;

  logic [NUM_SRC-1:0] use_hit;
  logic [NUM_SRC-1:0] m_hit;
  logic               advance;
  logic               load_e;
  logic               store_fwd;
  logic               stall;
  logic               unused_tags;

  always_comb begin
    d_tag          = '0;
    d_tag.valid    = bus.d_valid;
    d_tag.we       = bus.d_dst_we;
    d_tag.dst      = bus.d_dst_addr;
    d_tag.is_load  = bus.d_is_load;
    d_tag.is_store = bus.d_is_store;
    d_tag.src_used = bus.d_src_used;
    for (int i = 0; i < NUM_SRC; i++)
      d_tag.src_addr[i] = bus.d_src_addr[i*AW +: AW];
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [AW-1:0] da;
    logic          wb_hit;

    assign da = bus.d_src_addr[i*AW +: AW];

    assign use_hit[i] = bus.d_src_used[i]
                      & (da == e_tag.dst)
                      & addr_live(da, ZERO_REG);

    // Register-file write-through: W writes the reg D reads.
    assign wb_hit = w_tag.valid & w_tag.we
                  & (w_tag.dst == da)
                  & addr_live(da, ZERO_REG);

    assign d_opnd[i] = wb_hit ? bus.w_reg_write_data
                              : bus.d_src_data[i*DATA_W +: DATA_W];

    fwd_src_mux #(
      .DATA_W   (DATA_W),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_mux (
      .m_valid  (m_tag.valid),
      .m_we     (m_tag.we),
      .m_dst    (m_tag.dst),
      .w_valid  (w_tag.valid),
      .w_we     (w_tag.we),
      .w_dst    (w_tag.dst),
      .src_addr (e_tag.src_addr[i]),
      .src_used (e_tag.src_used[i]),
      .m_data   (bus.m_alu_result),
      .w_data   (bus.w_reg_write_data),
      .latched  (e_opnd_q[i]),
      .operand  (e_opnd[i]),
      .sel      (e_sel[i]),
      .match_m  (m_hit[i])
    );
  end

  assign stall = bus.d_valid & e_tag.valid & e_tag.is_load
               & e_tag.we & (|use_hit);

  assign advance = !bus.hold;
  assign load_e  = bus.d_valid & !stall & !bus.flush;

  assign store_fwd = w_tag.valid & w_tag.we & m_tag.is_store
                   & (w_tag.dst == m_tag.src_addr[1])
                   & addr_live(m_tag.src_addr[1], ZERO_REG);

  assign bus.stall        = stall;
  assign bus.e_operand    = e_opnd;
  assign bus.e_fwd_sel    = e_sel;
  assign bus.m_store_data = store_fwd ? bus.w_reg_write_data
                                      : m_store_q;
  assign bus.w_reg_we     = w_tag.valid & w_tag.we;
  assign bus.w_reg_addr   = w_tag.dst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_tag     <= '0;
      m_tag     <= '0;
      w_tag     <= '0;
      e_opnd_q  <= '0;
      m_store_q <= '0;
    end else if (advance) begin
      w_tag     <= m_tag;
      m_tag     <= e_tag;
      e_tag     <= load_e ? d_tag : '0;
      e_opnd_q  <= d_opnd;
      m_store_q <= e_opnd[1];
    end
  end

  // A load in M feeding E means the stall logic let it through.
  assert property (@(posedge clk) disable iff (rst)
    !(m_tag.is_load && (|m_hit)));

  assign unused_tags = ^{w_tag.is_load, w_tag.is_store,
                         w_tag.src_addr, w_tag.src_used,
                         m_tag.src_used, m_tag.src_addr[0]};

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit.
// Each step sets D/bypass inputs, clocks, and checks the outputs.
module tb_forwarding_hazard_unit;
  import forwarding_hazard_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  forwarding_hazard_unit_if #(
    .DATA_W (16), .AW (4), .NUM_SRC (2)
  ) bus ();

  forwarding_hazard_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic d_set(input logic        v,
                       input logic [1:0]  used,
                       input logic [3:0]  a0,
                       input logic [3:0]  a1,
                       input logic [3:0]  dst,
                       input logic        we,
                       input logic        ld,
                       input logic        st,
                       input logic [15:0] r0,
                       input logic [15:0] r1);
    bus.d_valid    = v;
    bus.d_src_used = used;
    bus.d_src_addr = {a1, a0};
    bus.d_src_data = {r1, r0};
    bus.d_dst_addr = dst;
    bus.d_dst_we   = we;
    bus.d_is_load  = ld;
    bus.d_is_store = st;
  endtask

  task automatic d_none();
    d_set(0, 2'b00, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic drain();
    d_none();
    bus.m_alu_result     = '0;
    bus.w_reg_write_data = '0;
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.hold = 1'b0;
    bus.flush = 1'b0;
    bus.m_alu_result = '0;
    bus.w_reg_write_data = '0;
    d_none();
    #12;
    chk("rst_stall", bus.stall, 0);
    chk("rst_sel", bus.e_fwd_sel, 0);
    chk("rst_wwe", bus.w_reg_we, 0);
    chk("rst_opnd", bus.e_operand, 0);
    chk("rst_store", bus.m_store_data, 0);
    tick();
    rst = 1'b0;

    // 1: add r1 ; add r2,r1,r1 -> both from M
    d_set(1, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0);
    tick();
    d_set(1, 2'b11, 1, 1, 2, 1, 0, 0, 0, 0);
    #1 chk("t1_nostall", bus.stall, 0);
    tick();
    d_none();
    bus.m_alu_result = 16'h1234;
    #1;
    chk("t1_opnd", bus.e_operand, 32'h12341234);
    chk("t1_sel", bus.e_fwd_sel, 4'b0101);

    // 2: r1 in W and M -> M wins
    drain();
    d_set(1, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0);
    tick();
    d_set(1, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0);
    tick();
    d_set(1, 2'b01, 1, 0, 3, 1, 0, 0, 0, 0);
    tick();
    d_none();
    bus.m_alu_result = 16'h0001;
    bus.w_reg_write_data = 16'hBEEF;
    #1;
    chk("t2_opnd0", bus.e_operand[15:0], 16'h0001);
    chk("t2_sel", bus.e_fwd_sel, 4'b0001);
    chk("t2_wwe", bus.w_reg_we, 1);
    chk("t2_waddr", bus.w_reg_addr, 1);

    // 3: ld r3 ; use r3 -> one stall, then W forward
    drain();
    d_set(1, 2'b00, 0, 0, 3, 1, 1, 0, 0, 0);
    tick();
    d_set(1, 2'b01, 3, 0, 6, 1, 0, 0, 0, 0);
    #1 chk("t3_stall", bus.stall, 1);
    tick();
    chk("t3_unstall", bus.stall, 0);
    chk("t3_bubble_sel", bus.e_fwd_sel, 0);
    tick();
    d_none();
    bus.m_alu_result = 16'hFFFF;
    bus.w_reg_write_data = 16'h5A5A;
    #1;
    chk("t3_opnd0", bus.e_operand[15:0], 16'h5A5A);
    chk("t3_sel", bus.e_fwd_sel, 4'b0010);
    chk("t3_wwe", bus.w_reg_we, 1);
    chk("t3_waddr", bus.w_reg_addr, 3);

    // 4: write-through latch of r5
    drain();
    d_set(1, 2'b00, 0, 0, 5, 1, 0, 0, 0, 0);
    tick();
    d_none();
    tick();
    tick();
    d_set(1, 2'b01, 5, 0, 7, 1, 0, 0, 16'h0000, 0);
    bus.w_reg_write_data = 16'hA5A5;
    tick();
    d_none();
    bus.w_reg_write_data = 16'h0000;
    #1;
    chk("t4_opnd0", bus.e_operand[15:0], 16'hA5A5);
    chk("t4_sel", bus.e_fwd_sel, 0);

    // 5: ld r4 ; st r4 -> MEM-MEM store data
    drain();
    d_set(1, 2'b00, 0, 0, 4, 1, 1, 0, 0, 0);
    tick();
    d_set(1, 2'b01, 0, 4, 0, 0, 0, 1, 16'h0100, 16'h1111);
    #1 chk("t5_nostall", bus.stall, 0);
    tick();
    d_none();
    #1 chk("t5_sel", bus.e_fwd_sel, 0);
    tick();
    bus.w_reg_write_data = 16'hCAFE;
    #1;
    chk("t5_store", bus.m_store_data, 16'hCAFE);
    chk("t5_waddr", bus.w_reg_addr, 4);

    // 5b: r0 never stalls or forwards
    drain();
    d_set(1, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0);
    tick();
    d_set(1, 2'b01, 0, 0, 8, 1, 0, 0, 16'h7777, 0);
    #1 chk("t5_r0_stall", bus.stall, 0);
    tick();
    d_none();
    bus.m_alu_result = 16'hFFFF;
    #1;
    chk("t5_r0_sel", bus.e_fwd_sel, 0);
    chk("t5_r0_opnd", bus.e_operand[15:0], 16'h7777);

    // 6: flush makes a bubble
    drain();
    d_set(1, 2'b00, 0, 0, 7, 1, 0, 0, 0, 0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    d_none();
    tick();
    tick();
    chk("t6_flush_wwe", bus.w_reg_we, 0);

    // 6b: hold freezes the tag pipeline
    drain();
    d_set(1, 2'b00, 0, 0, 9, 1, 0, 0, 0, 0);
    tick();
    d_none();
    bus.hold = 1'b1;
    tick();
    tick();
    bus.hold = 1'b0;
    tick();
    tick();
    chk("t6_hold_wwe", bus.w_reg_we, 1);
    chk("t6_hold_waddr", bus.w_reg_addr, 9);

    // 6c: reset mid-stream
    drain();
    d_set(1, 2'b00, 0, 0, 10, 1, 0, 0, 0, 0);
    tick();
    d_set(1, 2'b00, 0, 0, 11, 1, 0, 0, 0, 0);
    tick();
    d_set(1, 2'b01, 11, 0, 12, 1, 0, 0, 0, 0);
    tick();
    d_none();
    bus.m_alu_result = 16'h3333;
    #1;
    chk("t6_pre_sel", bus.e_fwd_sel, 4'b0001);
    chk("t6_pre_wwe", bus.w_reg_we, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_wwe", bus.w_reg_we, 0);
    chk("t6_rst_sel", bus.e_fwd_sel, 0);
    chk("t6_rst_opnd", bus.e_operand, 0);
    tick();
    rst = 1'b0;
    chk("t6_rst_stall", bus.stall, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
